// File: rtl/ps2_kb_rx_fifo.sv
// PS/2 keyboard receiver: filtered clock, 11-bit frame check, E0/F0 prefix merge, FWFT event FIFO.
// Optional macro RXKB_PARITY_CHECK_EN enables odd-parity checking of each frame.
module ps2_kb_rx_fifo #(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          PS_CLK,
  input  logic                          PS_DAT,
  output logic                          EVT_VALID,
  input  logic                          EVT_READY,
  output logic [7:0]                    EVT_CODE,
  output logic                          EVT_EXT,
  output logic                          EVT_BRK,
  output logic                          FRAME_ERR,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clkSync;
  logic [1:0]    datSync;
  logic          filtClk;
  logic [CW-1:0] filtCnt;
  logic          fallStb;
  logic          datBit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      clkSync <= '1;
      datSync <= '1;
    end else begin
      clkSync <= {clkSync[0], PS_CLK};
      datSync <= {datSync[0], PS_DAT};
    end
  end

  assign datBit = datSync[1];

  // Level is adopted on the FILT_LEN-th consecutive differing sample; the strobe is registered with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      filtClk <= 1'b1;
      filtCnt <= '0;
      fallStb <= 1'b0;
    end else begin
      fallStb <= 1'b0;
      if (clkSync[1] != filtClk) begin
        if (filtCnt == CW'(FILT_LEN - 1)) begin
          filtClk <= clkSync[1];
          filtCnt <= '0;
          fallStb <= ~clkSync[1];
        end else begin
          filtCnt <= filtCnt + 1'b1;
        end
      end else begin
        filtCnt <= '0;
      end
    end
  end

  state_t        state;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          parBit;
  logic [TW-1:0] tmoCnt;
  logic          extFlag;
  logic          brkFlag;

  logic          parityOk;
  logic          stopCheck;
  logic          stopOk;
  logic          stopFail;
  logic          tmoHit;
  logic          isE0;
  logic          isF0;
  logic          pushReq;
  logic [9:0]    pushEvt;

`ifdef RXKB_PARITY_CHECK_EN
  assign parityOk = ^{shiftReg, parBit};
`else
  assign parityOk = 1'b1;
`endif

  assign stopCheck = fallStb && (state == STOP);
  assign stopOk    = stopCheck && datBit && parityOk;
  assign stopFail  = stopCheck && !stopOk;
  assign tmoHit    = !fallStb && (state != IDLE) && (tmoCnt == TW'(TIMEOUT_CYC));
  assign isE0      = (shiftReg == 8'hE0);
  assign isF0      = (shiftReg == 8'hF0);
  assign pushReq   = stopOk && !isE0 && !isF0;
  assign pushEvt   = {extFlag, brkFlag, shiftReg};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parBit    <= 1'b0;
      tmoCnt    <= '0;
      extFlag   <= 1'b0;
      brkFlag   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= stopFail | tmoHit;

      if (state == IDLE || fallStb || tmoHit)
        tmoCnt <= '0;
      else
        tmoCnt <= tmoCnt + 1'b1;

      if (tmoHit) begin
        state <= IDLE;
      end else if (fallStb) begin
        unique case (state)
          IDLE: begin
            if (!datBit) begin
              state  <= DATA;
              bitCnt <= '0;
            end
          end
          DATA: begin
            shiftReg <= {datBit, shiftReg[7:1]};
            bitCnt   <= bitCnt + 1'b1;
            if (bitCnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parBit <= datBit;
            state  <= STOP;
          end
          STOP: state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (stopFail || tmoHit) begin
        extFlag <= 1'b0;
        brkFlag <= 1'b0;
      end else if (stopOk) begin
        if (isE0) begin
          extFlag <= 1'b1;
        end else if (isF0) begin
          brkFlag <= 1'b1;
        end else begin
          extFlag <= 1'b0;
          brkFlag <= 1'b0;
        end
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          full;
  logic          pop;
  logic          pushOk;

  assign EVT_VALID = (FIFO_LEVEL != '0);
  assign full      = (FIFO_LEVEL == LW'(FIFO_DEPTH));
  assign pop       = EVT_VALID && EVT_READY;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a simultaneous push.
  assign pushOk    = pushReq && (!full || pop);

  assign {EVT_EXT, EVT_BRK, EVT_CODE} = mem[rdPtr];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      FIFO_LEVEL <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      OVERFLOW <= pushReq && full && !pop;
      if (pushOk) begin
        mem[wrPtr] <= pushEvt;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      if (pushOk && !pop)
        FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
      else if (pop && !pushOk)
        FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_kb_rx_fifo.sv
// Directed bench for ps2_kb_rx_fifo: frames driven on the pins, events and pulses tallied by a monitor.
module tb_ps2_kb_rx_fifo;

  localparam int unsigned TMO = 2000;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PS_CLK = 1'b1;
  logic       PS_DAT = 1'b1;
  logic       EVT_READY = 1'b0;
  logic       EVT_VALID;
  logic [7:0] EVT_CODE;
  logic       EVT_EXT;
  logic       EVT_BRK;
  logic       FRAME_ERR;
  logic       OVERFLOW;
  logic [2:0] FIFO_LEVEL;

  int npass = 0;
  int ntotal = 0;
  int errCnt = 0;
  int ovfCnt = 0;
  int validCyc = 0;
  logic [9:0] popQ[$];

  ps2_kb_rx_fifo #(.FILT_LEN(4), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .PS_CLK(PS_CLK), .PS_DAT(PS_DAT),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_CODE(EVT_CODE),
    .EVT_EXT(EVT_EXT), .EVT_BRK(EVT_BRK), .FRAME_ERR(FRAME_ERR),
    .OVERFLOW(OVERFLOW), .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!RESET) begin
      if (FRAME_ERR) errCnt++;
      if (OVERFLOW) ovfCnt++;
      if (EVT_VALID) validCyc++;
      if (EVT_VALID && EVT_READY) popQ.push_back({EVT_EXT, EVT_BRK, EVT_CODE});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic sendBit(input logic b);
    PS_DAT = b;
    waitCycles(10);
    PS_CLK = 1'b0;
    waitCycles(20);
    PS_CLK = 1'b1;
    waitCycles(10);
  endtask

  task automatic sendFrameP(input logic [7:0] d, input logic par);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
    sendBit(par);
    sendBit(1'b1);
    PS_DAT = 1'b1;
    waitCycles(20);
  endtask

  task automatic sendFrame(input logic [7:0] d);
    sendFrameP(d, ~^d);
  endtask

  function automatic logic [9:0] popAt(input int k);
    if (popQ.size() > k) return popQ[k];
    return 10'h3FF;
  endfunction

  int e0, v0;

  initial begin
    waitCycles(4);
    check("rst_valid", EVT_VALID, 0);
    check("rst_code", EVT_CODE, 0);
    check("rst_ext_brk", {EVT_EXT, EVT_BRK}, 0);
    check("rst_pulses", {FRAME_ERR, OVERFLOW}, 0);
    check("rst_level", FIFO_LEVEL, 0);
    RESET = 1'b0;
    waitCycles(5);

    // single make code, consumer always ready
    EVT_READY = 1'b1;
    e0 = errCnt; v0 = validCyc;
    sendFrame(8'h1C);
    check("t1_pops", popQ.size(), 1);
    check("t1_evt", popAt(0), 10'h01C);
    check("t1_valid_cyc", validCyc - v0, 1);
    check("t1_ferr", errCnt - e0, 0);

    // extended break: E0 F0 75
    EVT_READY = 1'b0;
    popQ.delete();
    sendFrame(8'hE0);
    sendFrame(8'hF0);
    sendFrame(8'h75);
    check("t2_level", FIFO_LEVEL, 1);
    check("t2_head", {EVT_EXT, EVT_BRK, EVT_CODE}, 10'h375);
    EVT_READY = 1'b1;
    waitCycles(1);
    EVT_READY = 1'b0;
    waitCycles(2);
    check("t2_drained", FIFO_LEVEL, 0);
    check("t2_pop", popAt(0), 10'h375);

    // wrong parity bit on 0x1C
    e0 = errCnt;
    popQ.delete();
    sendFrameP(8'h1C, 1'b1);
`ifdef RXKB_PARITY_CHECK_EN
    check("t3_ferr", errCnt - e0, 1);
    check("t3_level", FIFO_LEVEL, 0);
`else
    check("t3_ferr", errCnt - e0, 0);
    check("t3_level", FIFO_LEVEL, 1);
    check("t3_head", {EVT_EXT, EVT_BRK, EVT_CODE}, 10'h01C);
    EVT_READY = 1'b1;
    waitCycles(1);
    EVT_READY = 1'b0;
    waitCycles(2);
`endif

    // fill past depth
    v0 = ovfCnt;
    popQ.delete();
    sendFrame(8'h16);
    sendFrame(8'h1E);
    sendFrame(8'h26);
    sendFrame(8'h25);
    check("t4_ovf_none", ovfCnt - v0, 0);
    sendFrame(8'h2E);
    check("t4_level", FIFO_LEVEL, 4);
    check("t4_ovf", ovfCnt - v0, 1);
    EVT_READY = 1'b1;
    waitCycles(8);
    EVT_READY = 1'b0;
    check("t4_npop", popQ.size(), 4);
    check("t4_pop0", popAt(0), 10'h016);
    check("t4_pop1", popAt(1), 10'h01E);
    check("t4_pop2", popAt(2), 10'h026);
    check("t4_pop3", popAt(3), 10'h025);
    check("t4_empty", FIFO_LEVEL, 0);

    // truncated frame then idle line
    e0 = errCnt;
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    waitCycles(TMO + 10);
    check("t5_tmo_ferr", errCnt - e0, 1);
    popQ.delete();
    EVT_READY = 1'b1;
    sendFrame(8'h29);
    check("t5_after", popAt(0), 10'h029);
    check("t5_npop", popQ.size(), 1);

    // glitches and reset mid-frame
    e0 = errCnt;
    popQ.delete();
    for (int g = 0; g < 3; g++) begin
      PS_CLK = 1'b0;
      waitCycles(1);
      PS_CLK = 1'b1;
      waitCycles(7);
    end
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    RESET = 1'b1;
    waitCycles(2);
    RESET = 1'b0;
    waitCycles(100);
    check("t6_no_evt", popQ.size(), 0);
    check("t6_no_ferr", errCnt - e0, 0);
    sendFrame(8'h5A);
    check("t6_evt", popAt(0), 10'h05A);
    check("t6_ferr_end", errCnt - e0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/ps2_kb_rx_fifo.md
# ps2_kb_rx_fifo

Parametrised PS/2 keyboard receiver that turns raw PS_CLK/PS_DAT line activity into complete key events. It filters the PS/2 clock, checks every 11-bit frame, and merges the E0 (extended) and F0 (break) prefix bytes into the event that follows them. Events are buffered in a small FIFO with a valid/ready handshake. It sits between the keyboard pins and the game-control logic, so consumers see one event per key action instead of raw scan bytes.

## Interface
- FILT_LEN, 4: consecutive identical CLK samples required before the filtered PS_CLK changes level (≥2).
- TIMEOUT_CYC, 50000: CLK cycles allowed between filtered PS_CLK falling edges inside a frame before the frame is aborted.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of two, ≥2.
- CLK  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- PS_CLK  in  1  raw PS/2 clock pin; asynchronous to CLK.
- PS_DAT  in  1  raw PS/2 data pin; asynchronous to CLK.
- EVT_VALID  out  1  FIFO head is valid.
- EVT_READY  in  1  consumer accepts the head on a cycle where VALID and READY are both high.
- EVT_CODE  out  8  scan code of the head event.
- EVT_EXT  out  1  head event was preceded by E0.
- EVT_BRK  out  1  head event is a release (preceded by F0).
- FRAME_ERR  out  1  one-cycle pulse when a frame is discarded.
- OVERFLOW  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  number of stored events.

## Operation
- Input stage:
  - PS_CLK and PS_DAT each pass through a 2-flop synchroniser; both flops reset to 1.
  - The filtered clock (resets to 1) takes the synchronised PS_CLK level only after FILT_LEN consecutive equal samples.
  - A falling edge of the filtered clock produces a one-cycle strobe, fall_stb.
- Frame FSM, advanced only on fall_stb:
  - IDLE: the sampled data bit must be 0 (start bit). If it is 1, stay in IDLE with no error.
  - DATA: shift 8 bits, LSB first.
  - PARITY: capture the parity bit.
  - STOP: the sampled bit must be 1. On success the byte goes to the decoder. On any failure, pulse FRAME_ERR, discard the byte, and clear both prefix flags. Return to IDLE in either case.
- Timeout:
  - The counter runs while the FSM is not in IDLE and clears on every fall_stb.
  - When it reaches TIMEOUT_CYC, the FSM returns to IDLE, FRAME_ERR pulses, and both prefix flags clear.
- Decoder, applied to each good byte:
  - 0xE0 sets ext_flag and produces no event.
  - 0xF0 sets brk_flag and produces no event.
  - Any other byte pushes {ext_flag, brk_flag, byte}, then clears both flags.
  - 0xE1 is handled as an ordinary code.
- FIFO:
  - First-word-fall-through: EVT_* always shows the head entry, and EVT_VALID = (FIFO_LEVEL != 0).
  - A pop occurs on any cycle with VALID and READY both high.
  - A push while full with no pop in the same cycle drops the new event and pulses OVERFLOW; the contents are unchanged.
  - A push and pop in the same cycle while full both succeed, the level stays at FIFO_DEPTH, and OVERFLOW stays 0.
  - A push and pop in the same cycle while empty is impossible, because VALID is 0.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset:
  - RESET high clears the FSM, counters, flags, and FIFO on the next edge, including in the middle of a frame.
  - A frame that is in flight when reset releases is lost without raising FRAME_ERR.
  - The receiver resynchronises on the next start bit.

## Timing
- Reset values: EVT_VALID=0, EVT_CODE=0x00, EVT_EXT=0, EVT_BRK=0, FRAME_ERR=0, OVERFLOW=0, FIFO_LEVEL=0.
- A clean pin falling edge produces fall_stb FILT_LEN+2 cycles later.
- If fall_stb for the stop bit occurs in cycle S:
  - the push happens at edge S+1;
  - EVT_VALID and FIFO_LEVEL update in S+1;
  - FRAME_ERR or OVERFLOW, if raised, is high during S+1 only.
- A pop at edge P updates EVT_* and FIFO_LEVEL in P+1.
- Glitches on PS_CLK shorter than FILT_LEN cycles produce no strobe.

## Configuration
- RXKB_PARITY_CHECK_EN defined: the 8 data bits plus the parity bit must contain an odd number of 1s. A mismatch discards the frame with FRAME_ERR.
- Macro undefined: the parity bit is sampled and ignored, and only the start bit, stop bit, and timeout checks apply.

## Test plan
- Frame 0x1C, parity 0, stop 1, EVT_READY=1 → one event {EXT=0, BRK=0, CODE=0x1C} with VALID high for 1 cycle, FRAME_ERR=0.
- Frames E0, F0, 0x75 with EVT_READY=0 → FIFO_LEVEL=1 and head {EXT=1, BRK=1, CODE=0x75}; prefix bytes create no entries.
- Frame 0x1C with parity bit 1 (macro defined) → FRAME_ERR pulses once and FIFO_LEVEL stays 0. With the macro undefined, the event is delivered.
- FIFO_DEPTH=4, EVT_READY=0, frames 0x16, 0x1E, 0x26, 0x25, 0x2E → FIFO_LEVEL=4 and OVERFLOW pulses once on the fifth frame. Draining yields 0x16, 0x1E, 0x26, 0x25.
- Start bit plus 3 data bits, then PS_CLK held high for TIMEOUT_CYC+10 cycles → FRAME_ERR pulses once. A following clean 0x29 frame is delivered correctly.
- 1-cycle low glitches on PS_CLK (FILT_LEN=4) during an idle line, plus RESET asserted mid-frame → no events and no FRAME_ERR. The next clean frame 0x5A is delivered.
